// File: rtl/dmem_responder_if.sv
// Core data-port and peripheral-bus bundle for dmem_responder.
// The master modport is the core/peripheral side; the slave modport is the responder.
interface dmem_responder_if;
  logic [31:0] i_addr;
  logic [3:0]  i_we;
  logic        i_rd;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_data;
  logic [3:0]  o_bus_be;
  logic        o_bus_req;
  logic        i_bus_ack;

  modport master (
    output i_addr, i_we, i_rd, i_data, i_bus_ack,
    input  o_data, o_valid, o_bus_addr, o_bus_data, o_bus_be, o_bus_req
  );

  modport slave (
    input  i_addr, i_we, i_rd, i_data, i_bus_ack,
    output o_data, o_valid, o_bus_addr, o_bus_data, o_bus_be, o_bus_req
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-port responder: zero-latency TCM reads/writes, MMIO writes posted to a FIFO drained by req/ack.
// Backpressure: o_valid drops only when the posted-write FIFO is full; strobes while stalled are dropped.
module dmem_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CNT_FULL);
    empty    = (cnt_q == '0);
    do_push  = push_vld && !full;
    do_pop   = pop_vld && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
    if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
    cnt      = cnt_q;
    head_dat = mem[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= push_dat;
  end
endmodule

module dmem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          FIFO_AW   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dmem_responder_if.slave dp
);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } mmio_wr_t;

  logic [3:0][7:0]   ram [2**RAM_AW];
  logic [RAM_AW-1:0] word_idx;
  logic              is_mmio, acc_vld, push_vld, pop_vld;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_cnt;
  mmio_wr_t          push_dat, head_dat;
  logic [31:0]       status_dat;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^dp.i_addr[1:0];

  always_comb begin
    is_mmio    = (dp.i_addr >= MMIO_BASE);
    word_idx   = dp.i_addr[RAM_AW+1:2];
    // Acceptance depends only on FIFO state, never on the incoming strobes.
    acc_vld    = !fifo_full;
    push_vld   = acc_vld && is_mmio && (|dp.i_we);
    pop_vld    = !fifo_empty && dp.i_bus_ack;
    push_dat   = '{addr: {dp.i_addr[31:2], 2'b00}, data: dp.i_data, be: dp.i_we};
    status_dat = {16'b0, 8'(fifo_cnt), 6'b0, fifo_full, fifo_empty};
  end

  dmem_fifo #(
    .W  ($bits(mmio_wr_t)),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .cnt      (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (acc_vld && !is_mmio) begin
      for (int k = 0; k < 4; k++) begin
        if (dp.i_we[k]) ram[word_idx][k] <= dp.i_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    dp.o_data = '0;
    if (dp.i_rd) dp.o_data = is_mmio ? status_dat : ram[word_idx];
    dp.o_valid    = !fifo_full;
    dp.o_bus_req  = !fifo_empty;
    dp.o_bus_addr = head_dat.addr;
    dp.o_bus_data = head_dat.data;
    dp.o_bus_be   = head_dat.be;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam int          DEPTH     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if dp_if ();

  dmem_responder #(.RAM_AW(10), .MMIO_BASE(MMIO_BASE), .FIFO_AW(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .dp      (dp_if)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [int];
  logic [67:0] q [$];

  logic        last_valid, last_req;
  logic [31:0] last_data, last_bus_addr, last_bus_data;
  logic [3:0]  last_bus_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] status_m();
    int n = q.size();
    return {16'b0, 8'(n), 6'b0, n == DEPTH, n == 0};
  endfunction

  // One core cycle: drive after negedge, compare against the model, then apply the edge to the model.
  task automatic cycle(input logic [31:0] a, input logic [3:0] we, input logic rd,
                       input logic [31:0] d, input logic ack);
    logic        mmio, acc, pop;
    int          idx;
    logic [31:0] w;
    logic [67:0] head;
    @(negedge clk);
    dp_if.i_addr = a; dp_if.i_we = we; dp_if.i_rd = rd; dp_if.i_data = d; dp_if.i_bus_ack = ack;
    #1;
    mmio = (a >= MMIO_BASE);
    idx  = int'(a[11:2]);
    last_valid = dp_if.o_valid; last_req = dp_if.o_bus_req; last_data = dp_if.o_data;
    last_bus_addr = dp_if.o_bus_addr; last_bus_data = dp_if.o_bus_data; last_bus_be = dp_if.o_bus_be;
    chk("valid", {31'b0, last_valid}, {31'b0, q.size() < DEPTH});
    chk("bus_req", {31'b0, last_req}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      head = q[0];
      chk("bus_addr", last_bus_addr, head[67:36]);
      chk("bus_data", last_bus_data, head[35:4]);
      chk("bus_be", {28'b0, last_bus_be}, {28'b0, head[3:0]});
    end
    if (!rd) chk("data_idle", last_data, 32'h0);
    else if (mmio) chk("status", last_data, status_m());
    else if (ram_m.exists(idx)) chk("ram_rd", last_data, ram_m[idx]);
    @(posedge clk);
    acc = (q.size() < DEPTH);
    pop = ack && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (acc && mmio && we != 4'h0) q.push_back({a & 32'hFFFF_FFFC, d, we});
    if (acc && !mmio && we != 4'h0 && (ram_m.exists(idx) || we == 4'hF)) begin
      w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
      for (int k = 0; k < 4; k++) if (we[k]) w[8*k +: 8] = d[8*k +: 8];
      ram_m[idx] = w;
    end
  endtask

  task automatic idle(input logic ack);
    cycle(32'h0, 4'h0, 1'b0, 32'h0, ack);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  we;
    int          op;
    dp_if.i_addr = '0; dp_if.i_we = '0; dp_if.i_rd = 1'b0; dp_if.i_data = '0; dp_if.i_bus_ack = 1'b0;
    #3;
    chk("reset_valid", {31'b0, dp_if.o_valid}, 32'h1);
    chk("reset_req", {31'b0, dp_if.o_bus_req}, 32'h0);
    #4 rst_n = 1'b1;

    cycle(MMIO_BASE, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("reset_status", last_data, 32'h0000_0001);

    // RAM byte lanes and aliasing
    cycle(32'h100, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    cycle(32'h100, 4'h2, 1'b0, 32'h0000_5500, 1'b0);
    cycle(32'h102, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("byte_merge", last_data, 32'hDEAD_55EF);
    cycle(32'h102, 4'h0, 1'b0, 32'h0, 1'b0);
    chk("clean_data", last_data, 32'h0);
    cycle(32'h1004, 4'hF, 1'b0, 32'h1234_5678, 1'b0);
    cycle(32'h0004, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("alias", last_data, 32'h1234_5678);
    cycle(32'h0004, 4'hF, 1'b1, 32'hAAAA_5555, 1'b0);
    chk("rd_wr_same_cycle_old", last_data, 32'h1234_5678);

    // Fill the FIFO, try a stalled write, then drain in order
    for (int i = 0; i < 4; i++)
      cycle(MMIO_BASE + 32'(4 * i), 4'hF, 1'b0, 32'(i + 1), 1'b0);
    cycle(MMIO_BASE + 32'h10, 4'hF, 1'b0, 32'h5, 1'b0);
    chk("full_stall", {31'b0, last_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain_order", last_bus_data, 32'(i + 1));
      chk("drain_valid", {31'b0, last_valid}, (i == 0) ? 32'h0 : 32'h1);
    end
    idle(1'b0);
    chk("stalled_not_pushed", {31'b0, last_req}, 32'h0);

    // Simultaneous push and pop at count 2
    cycle(MMIO_BASE, 4'hF, 1'b0, 32'hA0, 1'b0);
    cycle(MMIO_BASE + 32'h4, 4'hF, 1'b0, 32'hA1, 1'b0);
    cycle(MMIO_BASE + 32'h8, 4'hF, 1'b0, 32'hA2, 1'b1);
    cycle(MMIO_BASE, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("push_pop_status", last_data, 32'h0000_0200);
    chk("push_pop_head", last_bus_data, 32'hA1);

    // Async reset with three entries pending
    cycle(MMIO_BASE + 32'hC, 4'hF, 1'b0, 32'hA3, 1'b0);
    @(negedge clk);
    dp_if.i_we = '0; dp_if.i_rd = 1'b0; dp_if.i_bus_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, dp_if.o_bus_req}, 32'h0);
    chk("async_rst_valid", {31'b0, dp_if.o_valid}, 32'h1);
    q.delete();
    #1 rst_n = 1'b1;
    cycle(MMIO_BASE, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("post_rst_status", last_data, 32'h0000_0001);
    cycle(32'h100, 4'h0, 1'b1, 32'h0, 1'b0);
    chk("ram_survives_rst", last_data, 32'hDEAD_55EF);

    // Ack on empty FIFO, then a single push
    for (int i = 0; i < 3; i++) begin
      cycle(MMIO_BASE, 4'h0, 1'b1, 32'h0, 1'b1);
      chk("empty_ack_status", last_data, 32'h0000_0001);
    end
    cycle(MMIO_BASE + 32'hABE, 4'h5, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle(1'b0);
    chk("single_push_req", {31'b0, last_req}, 32'h1);
    chk("single_push_addr", last_bus_addr, 32'h8000_0ABC);
    chk("single_push_data", last_bus_data, 32'hCAFE_F00D);
    chk("single_push_be", {28'b0, last_bus_be}, 32'h5);
    idle(1'b1);

    // Randomized mix of RAM and MMIO traffic with random acks
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 19);
      d  = $urandom;
      we = 4'($urandom_range(1, 15));
      if (op < 8) begin
        a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        cycle(a, we, $urandom_range(0, 3) == 0, d, 1'($urandom_range(0, 1)));
      end else if (op < 13) begin
        a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 31)) << 2);
        cycle(a, 4'h0, 1'b1, d, 1'($urandom_range(0, 1)));
      end else if (op < 17) begin
        a = MMIO_BASE | ($urandom & 32'h7FFF_FFFF);
        cycle(a, we, 1'b0, d, 1'($urandom_range(0, 2) == 0));
      end else if (op < 19) begin
        cycle(MMIO_BASE | ($urandom & 32'h7FFF_FFFF), 4'h0, 1'b1, d, 1'($urandom_range(0, 1)));
      end else begin
        idle(1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder on the CPU core's data port. Receives address, byte write enables, read strobe and write data from the core's memory-access stage; returns read data and the data-port valid (clock enable) signal.
- Contains a local tightly coupled data RAM with single-cycle access.
- Writes to the MMIO window go into a posted-write FIFO, which drains to an external peripheral bus over a req/ack handshake. While the FIFO is full, o_valid stalls the core.

Parameters:
- RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words, 4 KiB).
- MMIO_BASE, 32'h8000_0000, addresses >= MMIO_BASE are MMIO; addresses below it are RAM.
- FIFO_AW, 2, log2 of posted-write FIFO depth (default 4 entries).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_addr  in  32  byte address from the core; bits [1:0] are ignored (word access).
- i_we  in  4  byte-lane write enables; already qualified by the core's clock enable.
- i_rd  in  1  read strobe; already qualified by the core's clock enable.
- i_data  in  32  write data, lane-aligned by the core.
- o_data  out  32  read data, full word; the core performs lane shift and sign extension.
- o_valid  out  1  data-port ready; low stalls the entire core pipeline.
- o_bus_addr  out  32  head FIFO entry address.
- o_bus_data  out  32  head FIFO entry data.
- o_bus_be  out  4  head FIFO entry byte enables.
- o_bus_req  out  1  head entry present (FIFO not empty).
- i_bus_ack  in  1  peripheral accepts the head entry when o_bus_req && i_bus_ack.

Behaviour:
- Reset (async, i_rst_n=0):
  - FIFO read pointer, write pointer and count are cleared to 0; pending entries are discarded.
  - o_bus_req=0 immediately and o_valid=1.
  - RAM contents are not reset.
- o_valid = !full, where full = (count == 2**FIFO_AW).
  - o_valid is derived only from registered state. It must never depend combinationally on i_addr, i_we or i_rd, because the core gates its strobes with valid.
- Request acceptance:
  - A request is accepted only in a cycle with o_valid=1.
  - Strobes arriving while o_valid=0 are ignored: no RAM write, no push.
- RAM region (i_addr < MMIO_BASE):
  - Word index is i_addr[RAM_AW+1:2]; higher bits are ignored, so accesses alias modulo the RAM size.
  - Read is combinational (asynchronous array read) in the same cycle, so there is zero-latency data for the core's write-back register.
  - Write: on the rising edge, each byte lane k with i_we[k]=1 is updated from i_data[8k+7:8k]; other lanes are unchanged.
  - Read-after-write: a read in cycle N+1 returns the data written in cycle N. A read and write in the same cycle returns the old data.
- MMIO region (i_addr >= MMIO_BASE, unsigned compare):
  - Write (|i_we, accepted): push {i_addr with [1:0] cleared, i_data, i_we} into the FIFO. The RAM is not touched.
  - Read: returns status {16'b0, count zero-extended to 8 bits, 6'b0, full, empty}, where count is the value before any same-edge push or pop. No side effects.
- o_data is 32'h0 whenever i_rd=0 (clean-data rule).
- FIFO:
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Pop when o_bus_req && i_bus_ack.
  - Pointers wrap modulo 2**FIFO_AW; count is FIFO_AW+1 bits wide.
  - o_bus_* outputs are driven from the head storage entry and are stable while o_bus_req=1 && i_bus_ack=0.
  - i_bus_ack with empty FIFO is ignored: no pointer change, no underflow.
- Full and drain: o_valid returns to 1 in the cycle after the pop edge that leaves count < depth.
- Write ordering: RAM writes and MMIO writes are not ordered against each other. MMIO writes leave in push order.
- Write-side stall latency: 0 cycles. A write into the last free slot completes, and o_valid drops on the following cycle.

Test Plan:
- RAM byte write: write 32'hDEADBEEF with we=4'hF to 0x100, then we=4'h2 with data 32'h0000_5500 to 0x100, then i_rd at 0x102 -> o_data=32'hDEAD55EF in the same cycle. o_data=0 when i_rd=0.
- Aliasing: with RAM_AW=10, write 32'h1234_5678 to 0x0000_1004, then read 0x0000_0004 -> 32'h1234_5678.
- MMIO posting and draining:
  - Setup: i_bus_ack held at 0; write 4 words (data 1..4) to 0x8000_0000..0x8000_000C.
  - Expect o_valid=0 after the 4th write edge.
  - A 5th write presented while o_valid=0 is not pushed (count stays 4).
  - Raise i_bus_ack for one cycle -> entry 1 pops and o_valid=1 next cycle. Remaining pops emit data 2,3,4 in order.
- Simultaneous push/pop at count=2: MMIO write with i_bus_ack=1 -> count stays 2, head advances. A status read at 0x8000_0000 returns 32'h0000_0200.
- Async reset mid-drain: with count=3 and o_bus_req=1, assert i_rst_n=0 between clock edges -> o_bus_req=0 and o_valid=1 immediately. After release, a status read returns 32'h0000_0001. RAM data written before reset still reads back.
- Ack on empty: i_bus_ack=1 with empty FIFO for 3 cycles -> count stays 0, no pointer movement, and a subsequent single push appears at o_bus_* correctly.
